register_sin_deserializer: RTL and testbench

- Serial-in, parallel-out receiver. It is the receiving end of the LSB-first serial stream produced by the team's right-shifting register through its `right_carry` output.
- After a start strobe, it collects WIDTH bits on qualified `shift_en` cycles and reassembles them into a word.
- It presents the word on `data_out` with a one-cycle `valid` pulse.
- It sits between a shifting transmitter and any parallel consumer.

---
 rtl/register_sin_deserializer_pkg.sv | 11 +
 rtl/register_sin_deserializer_if.sv | 24 ++
 rtl/register_sin_deserializer_bit_counter.sv | 38 +++
 rtl/register_sin_deserializer.sv | 104 ++++++++++
 tb/tb_register_sin_deserializer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_sin_deserializer_pkg.sv
// Shared types and defaults for the serial-in word deserializer.
package deser_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/register_sin_deserializer_if.sv
// Control, serial input and parallel result bundle of the deserializer.
interface register_sin_deserializer_if
    #(parameter int WIDTH = deser_pkg::DEF_WIDTH);

    logic             clr;
    logic             start;
    logic             shift_en;
    logic             serial_in;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output clr, start, shift_en, serial_in,
        input  data_out, valid, busy, overrun
    );

    modport slave (
        input  clr, start, shift_en, serial_in,
        output data_out, valid, busy, overrun
    );

endinterface

// File: rtl/register_sin_deserializer_bit_counter.sv
// Bit counter with sync clear/increment and a WIDTH-1 terminal flag.
module bit_counter_clr_inc
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/register_sin_deserializer.sv
// LSB-first serial-in, parallel-out receiver with valid pulse and
// sticky overrun flag for a start seen mid-word.
module register_sin_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    register_sin_deserializer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    logic             tc;
    logic             sample;
    logic             done;
    logic             cnt_clr;
    logic [WIDTH-1:0] shifted;

    assign sample  = (state_q == RECV) && bus.shift_en;
    assign done    = sample && tc;
    assign shifted = {bus.serial_in, shreg_q[WIDTH-1:1]};
    assign cnt_clr = bus.clr || done ||
                     ((state_q == IDLE) && bus.start);

    bit_counter_clr_inc #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (sample),
        .tc  (tc)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;
        if (bus.clr) begin
            state_d    = IDLE;
            shreg_d    = '0;
            data_out_d = '0;
            overrun_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RECV;
                        shreg_d = '0;
                    end
                end
                RECV: begin
                    // start mid-word only flags; the word still completes
                    if (bus.start) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.shift_en) begin
                        shreg_d = shifted;
                        if (tc) begin
                            data_out_d = shifted;
                            valid_d    = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_register_sin_deserializer.sv
// Scenario tasks plus randomized traffic against a word-level model.
module tb_register_sin_deserializer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_sin_deserializer_if #(.WIDTH(W)) bus ();

    register_sin_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit         m_rx;
    int         m_n;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    task automatic model_reset();
        m_rx = 0; m_n = 0; m_acc = '0;
        m_data = '0; m_valid = 0; m_ovr = 0;
    endtask

    // drive one cycle of inputs, advance the model, sample after the edge
    task automatic tick(input logic c, s, e, d);
        bus.clr = c; bus.start = s;
        bus.shift_en = e; bus.serial_in = d;
        m_valid = 0;
        if (c) begin
            m_rx = 0; m_n = 0; m_acc = '0;
            m_data = '0; m_ovr = 0;
        end else if (!m_rx) begin
            if (s) begin
                m_rx = 1; m_n = 0; m_acc = '0;
            end
        end else begin
            if (s) m_ovr = 1;
            if (e) begin
                m_acc = m_acc | (W'(d) << m_n);
                m_n++;
                if (m_n == W) begin
                    m_data = m_acc; m_valid = 1; m_rx = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.clr = 0; bus.start = 0;
        bus.shift_en = 0; bus.serial_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.data_out, bus.valid, bus.busy, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL reset got d=%h v=%b b=%b o=%b exp all 0",
                     bus.data_out, bus.valid, bus.busy, bus.overrun);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] bits;
        bits = 4'b1101;
        tick(0, 1, 0, 0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1", bus.busy);
        end
        for (int i = 0; i < W; i++) begin
            tick(0, 0, 1, bits[i]);
            checks++;
            if ({bus.data_out, bus.valid, bus.busy, bus.overrun} !==
                {m_data, m_valid, m_rx, m_ovr}) begin
                errors++;
                $display("FAIL basic_bit%0d got d=%h v=%b b=%b o=%b exp d=%h v=%b b=%b o=%b",
                         i, bus.data_out, bus.valid, bus.busy, bus.overrun,
                         m_data, m_valid, m_rx, m_ovr);
            end
        end
        checks++;
        if ({bus.data_out, bus.valid, bus.busy} !== {4'hD, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_word got d=%h v=%b b=%b exp d=d v=1 b=0",
                     bus.data_out, bus.valid, bus.busy);
        end
        tick(0, 0, 0, 0);
        checks++;
        if ({bus.data_out, bus.valid} !== {4'hD, 1'b0}) begin
            errors++;
            $display("FAIL basic_pulse got d=%h v=%b exp d=d v=0",
                     bus.data_out, bus.valid);
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] bits;
        bits = 4'b1101;
        tick(0, 1, 0, 0);
        for (int i = 0; i < W; i++) begin
            tick(0, 0, 1, bits[i]);
            checks++;
            if (bus.valid !== (i == W - 1)) begin
                errors++;
                $display("FAIL gaps_valid%0d got %b exp %b",
                         i, bus.valid, (i == W - 1));
            end
            if (i != W - 1) begin
                repeat (2) begin
                    tick(0, 0, 0, ~bits[i]);
                    checks++;
                    if ({bus.valid, bus.busy} !== 2'b01) begin
                        errors++;
                        $display("FAIL gaps_hold got v=%b b=%b exp v=0 b=1",
                                 bus.valid, bus.busy);
                    end
                end
            end
        end
        checks++;
        if (bus.data_out !== 4'hD) begin
            errors++;
            $display("FAIL gaps_word got %h exp d", bus.data_out);
        end
    endtask

    task automatic test_overrun();
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 0);
        checks++;
        if ({bus.overrun, bus.busy} !== 2'b11) begin
            errors++;
            $display("FAIL ovr_set got o=%b b=%b exp o=1 b=1",
                     bus.overrun, bus.busy);
        end
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        checks++;
        if ({bus.data_out, bus.valid, bus.overrun} !== {4'hC, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovr_word got d=%h v=%b o=%b exp d=c v=1 o=1",
                     bus.data_out, bus.valid, bus.overrun);
        end
        tick(1, 0, 0, 0);
        checks++;
        if ({bus.data_out, bus.overrun, bus.busy} !== {4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovr_clr got d=%h o=%b b=%b exp d=0 o=0 b=0",
                     bus.data_out, bus.overrun, bus.busy);
        end
    endtask

    task automatic test_clr_start();
        tick(1, 1, 0, 0);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_start got b=%b exp 0", bus.busy);
        end
        tick(0, 1, 1, 1);
        for (int i = 0; i < W; i++) tick(0, 0, 1, 0);
        checks++;
        if ({bus.data_out, bus.valid, bus.busy} !== {4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_shift got d=%h v=%b b=%b exp d=0 v=1 b=0",
                     bus.data_out, bus.valid, bus.busy);
        end
    endtask

    task automatic test_rst_mid();
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 1);
        checks++;
        if ({bus.busy, bus.data_out} !== {1'b1, 4'hD}) begin
            errors++;
            $display("FAIL rst_pre got b=%b d=%h exp b=1 d=d",
                     bus.busy, bus.data_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.data_out, bus.valid, bus.busy, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL rst_async got d=%h v=%b b=%b o=%b exp all 0",
                     bus.data_out, bus.valid, bus.busy, bus.overrun);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w0, w1;
        int pulses;
        w0 = 4'hA; w1 = 4'h5; pulses = 0;
        tick(0, 1, 0, 0);
        for (int i = 0; i < W; i++) begin
            tick(0, 0, 1, w0[i]);
            if (bus.valid) pulses++;
        end
        checks++;
        if (bus.data_out !== 4'hA) begin
            errors++;
            $display("FAIL b2b_w0 got %h exp a", bus.data_out);
        end
        tick(0, 1, 0, 0);
        if (bus.valid) pulses++;
        for (int i = 0; i < W; i++) begin
            tick(0, 0, 1, w1[i]);
            if (bus.valid) pulses++;
        end
        checks++;
        if ({bus.data_out, bus.overrun, pulses[3:0]} !== {4'h5, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL b2b_w1 got d=%h o=%b p=%0d exp d=5 o=0 p=2",
                     bus.data_out, bus.overrun, pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 100; i++) begin
            tick(($urandom % 16) == 0, ($urandom % 5) == 0,
                 1'($urandom % 2), 1'($urandom % 2));
            checks++;
            if ({bus.data_out, bus.valid, bus.busy, bus.overrun} !==
                {m_data, m_valid, m_rx, m_ovr}) begin
                errors++;
                $display("FAIL rand%0d got d=%h v=%b b=%b o=%b exp d=%h v=%b b=%b o=%b",
                         i, bus.data_out, bus.valid, bus.busy, bus.overrun,
                         m_data, m_valid, m_rx, m_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_clr_start();
        tick(0, 0, 0, 0);
        test_basic();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
